// File: rtl/eth_mac_cfg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : eth_mac_cfg_pkg
// Description : Shared types, register map and vector bit positions for the
//               10G MAC runtime configuration sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package eth_mac_cfg_pkg;

    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_DRAIN  = 3'd1;
    localparam state_t ST_QUIET  = 3'd2;
    localparam state_t ST_APPLY  = 3'd3;
    localparam state_t ST_ENABLE = 3'd4;

    localparam logic [1:0] ADDR_MAC_LO = 2'd0;
    localparam logic [1:0] ADDR_MAC_HI = 2'd1;
    localparam logic [1:0] ADDR_CTRL   = 2'd2;
    localparam logic [1:0] ADDR_STATUS = 2'd3;

    localparam int CTRL_TX_EN  = 0;
    localparam int CTRL_RX_EN  = 1;
    localparam int CTRL_JUMBO  = 2;
    localparam int CTRL_VLAN   = 3;
    localparam int CTRL_COMMIT = 4;
    localparam int CTRL_CLR    = 6;

    localparam int VEC_MAC_HI    = 79;
    localparam int VEC_MAC_LO    = 32;
    localparam int VEC_MAXLEN_HI = 30;
    localparam int VEC_MAXLEN_LO = 16;
    localparam int VEC_JUMBO     = 4;
    localparam int VEC_VLAN      = 2;
    localparam int VEC_EN        = 1;
    localparam int VEC_RX_LENCHK = 9;
    localparam int VEC_RX_LTCHK  = 8;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/eth_mac_cfg_regs.sv
`default_nettype none
// ============================================================================
// Module      : eth_mac_cfg_regs
// Description : Shadow configuration registers, read mux and sticky flags.
// Revision    : 1.0 - initial release
// ============================================================================
module eth_mac_cfg_regs
    import eth_mac_cfg_pkg::*;
#(
    parameter logic [47:0] SRC_MAC = 48'h001122334455
) (
    input  logic        clk156,
    input  logic        sys_rst,
    input  logic        cfg_wr_en_i,
    input  logic [1:0]  cfg_addr_i,
    input  logic [31:0] cfg_wr_data_i,
    input  state_t      state_i,
    input  logic        drain_timeout_set_i,
    output logic [31:0] rd_data_o,
    output logic [47:0] mac_o,
    output logic        tx_en_req_o,
    output logic        rx_en_req_o,
    output logic        jumbo_o,
    output logic        vlan_o,
    output logic        commit_o
);

    logic [47:0] mac_q, mac_d;
    logic [3:0]  ctrl_q, ctrl_d;
    logic        drain_to_q, drain_to_d;
    logic        commit_err_q, commit_err_d;
    logic        w_busy;
    logic        w_ctrl_wr;
    logic        w_commit_req;

    assign w_busy       = (state_i != ST_IDLE);
    assign w_ctrl_wr    = cfg_wr_en_i && (cfg_addr_i == ADDR_CTRL);
    assign w_commit_req = w_ctrl_wr && cfg_wr_data_i[CTRL_COMMIT];
    assign commit_o     = w_commit_req && !w_busy;

    always_comb begin
        mac_d        = mac_q;
        ctrl_d       = ctrl_q;
        drain_to_d   = drain_to_q;
        commit_err_d = commit_err_q;
        if (cfg_wr_en_i) begin
            case (cfg_addr_i)
                ADDR_MAC_LO: mac_d[31:0]  = cfg_wr_data_i;
                ADDR_MAC_HI: mac_d[47:32] = cfg_wr_data_i[15:0];
                ADDR_CTRL:   ctrl_d       = cfg_wr_data_i[3:0];
                default:     ;
            endcase
        end
        // Clear first so an event in the same cycle still leaves its flag set.
        if (w_ctrl_wr && cfg_wr_data_i[CTRL_CLR]) begin
            drain_to_d   = 1'b0;
            commit_err_d = 1'b0;
        end
        if (drain_timeout_set_i)
            drain_to_d = 1'b1;
        if (w_commit_req && w_busy)
            commit_err_d = 1'b1;
    end

    always_ff @(posedge clk156) begin
        if (sys_rst) begin
            mac_q        <= SRC_MAC;
            ctrl_q       <= 4'hF;
            drain_to_q   <= 1'b0;
            commit_err_q <= 1'b0;
        end else begin
            mac_q        <= mac_d;
            ctrl_q       <= ctrl_d;
            drain_to_q   <= drain_to_d;
            commit_err_q <= commit_err_d;
        end
    end

    always_comb begin
        rd_data_o = '0;
        case (cfg_addr_i)
            ADDR_MAC_LO: rd_data_o        = mac_q[31:0];
            ADDR_MAC_HI: rd_data_o[15:0]  = mac_q[47:32];
            ADDR_CTRL:   rd_data_o[3:0]   = ctrl_q;
            default:     rd_data_o[5:0]   = {commit_err_q, drain_to_q, state_i, w_busy};
        endcase
    end

    assign mac_o       = mac_q;
    assign tx_en_req_o = ctrl_q[CTRL_TX_EN];
    assign rx_en_req_o = ctrl_q[CTRL_RX_EN];
    assign jumbo_o     = ctrl_q[CTRL_JUMBO];
    assign vlan_o      = ctrl_q[CTRL_VLAN];

endmodule
`default_nettype wire

// File: rtl/eth_mac_cfg_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : eth_mac_cfg_ctrl
// Description : Commit sequencer driving the 10G MAC TX/RX configuration
//               vectors: disable, drain, quiet gap, apply, re-enable on link.
// Revision    : 1.0 - initial release
// ============================================================================
module eth_mac_cfg_ctrl
    import eth_mac_cfg_pkg::*;
#(
    parameter logic [47:0] SRC_MAC       = 48'h001122334455,
    parameter int          MAX_FRAME     = 1518,
    parameter int          DRAIN_TIMEOUT = 4096,
    parameter int          QUIET_CYCLES  = 16
) (
    input  logic        clk156,
    input  logic        sys_rst,
    input  logic        cfg_wr_en,
    input  logic [1:0]  cfg_addr,
    input  logic [31:0] cfg_wr_data,
    output logic [31:0] cfg_rd_data,
    input  logic        link_up,
    input  logic        tx_idle,
    input  logic        rx_idle,
    output logic [79:0] mac_tx_configuration_vector,
    output logic [79:0] mac_rx_configuration_vector,
    output logic        cfg_busy,
    output logic        cfg_done
);

    localparam logic [15:0] c_drain_last = 16'(DRAIN_TIMEOUT - 1);
    localparam logic [15:0] c_quiet_last = 16'(QUIET_CYCLES - 1);
    localparam logic [14:0] c_max_frame  = 15'(MAX_FRAME);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [47:0] mac_act_q, mac_act_d;
    logic        jumbo_act_q, jumbo_act_d;
    logic        vlan_act_q, vlan_act_d;
    logic        tx_en_q, tx_en_d;
    logic        rx_en_q, rx_en_d;
    logic        done_q, done_d;

    logic        w_drain_to_set;
    logic        w_commit;
    logic [47:0] w_sh_mac;
    logic        w_sh_tx_en, w_sh_rx_en, w_sh_jumbo, w_sh_vlan;

    eth_mac_cfg_regs #(
        .SRC_MAC (SRC_MAC)
    ) u_regs (
        .clk156              (clk156),
        .sys_rst             (sys_rst),
        .cfg_wr_en_i         (cfg_wr_en),
        .cfg_addr_i          (cfg_addr),
        .cfg_wr_data_i       (cfg_wr_data),
        .state_i             (state_q),
        .drain_timeout_set_i (w_drain_to_set),
        .rd_data_o           (cfg_rd_data),
        .mac_o               (w_sh_mac),
        .tx_en_req_o         (w_sh_tx_en),
        .rx_en_req_o         (w_sh_rx_en),
        .jumbo_o             (w_sh_jumbo),
        .vlan_o              (w_sh_vlan),
        .commit_o            (w_commit)
    );

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        mac_act_d      = mac_act_q;
        jumbo_act_d    = jumbo_act_q;
        vlan_act_d     = vlan_act_q;
        tx_en_d        = tx_en_q;
        rx_en_d        = rx_en_q;
        done_d         = 1'b0;
        w_drain_to_set = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (w_commit) begin
                    state_d = ST_DRAIN;
                    cnt_d   = '0;
                    tx_en_d = 1'b0;
                    rx_en_d = 1'b0;
                end
            end
            ST_DRAIN: begin
                // An idle datapath wins over a coincident timeout.
                if (tx_idle && rx_idle) begin
                    state_d = ST_QUIET;
                    cnt_d   = '0;
                end else if (cnt_q == c_drain_last) begin
                    state_d        = ST_QUIET;
                    cnt_d          = '0;
                    w_drain_to_set = 1'b1;
                end else begin
                    cnt_d = sat_inc16(cnt_q);
                end
            end
            ST_QUIET: begin
                if (cnt_q == c_quiet_last) begin
                    state_d = ST_APPLY;
                    cnt_d   = '0;
                end else begin
                    cnt_d = sat_inc16(cnt_q);
                end
            end
            ST_APPLY: begin
                mac_act_d   = w_sh_mac;
                jumbo_act_d = w_sh_jumbo;
                vlan_act_d  = w_sh_vlan;
                state_d     = ST_ENABLE;
            end
            ST_ENABLE: begin
                if (link_up) begin
                    tx_en_d = w_sh_tx_en;
                    rx_en_d = w_sh_rx_en;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk156) begin
        if (sys_rst) begin
            state_q     <= ST_ENABLE;
            cnt_q       <= '0;
            mac_act_q   <= SRC_MAC;
            jumbo_act_q <= 1'b1;
            vlan_act_q  <= 1'b1;
            tx_en_q     <= 1'b0;
            rx_en_q     <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mac_act_q   <= mac_act_d;
            jumbo_act_q <= jumbo_act_d;
            vlan_act_q  <= vlan_act_d;
            tx_en_q     <= tx_en_d;
            rx_en_q     <= rx_en_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        mac_tx_configuration_vector = '0;
        mac_tx_configuration_vector[VEC_MAC_HI:VEC_MAC_LO]       = mac_act_q;
        mac_tx_configuration_vector[VEC_MAXLEN_HI:VEC_MAXLEN_LO] = c_max_frame;
        mac_tx_configuration_vector[VEC_JUMBO]                   = jumbo_act_q;
        mac_tx_configuration_vector[VEC_VLAN]                    = vlan_act_q;
        mac_tx_configuration_vector[VEC_EN]                      = tx_en_q;

        mac_rx_configuration_vector = '0;
        mac_rx_configuration_vector[VEC_MAC_HI:VEC_MAC_LO]       = mac_act_q;
        mac_rx_configuration_vector[VEC_MAXLEN_HI:VEC_MAXLEN_LO] = c_max_frame;
        mac_rx_configuration_vector[VEC_RX_LENCHK]               = 1'b1;
        mac_rx_configuration_vector[VEC_RX_LTCHK]                = 1'b1;
        mac_rx_configuration_vector[VEC_JUMBO]                   = jumbo_act_q;
        mac_rx_configuration_vector[VEC_VLAN]                    = vlan_act_q;
        mac_rx_configuration_vector[VEC_EN]                      = rx_en_q;
    end

    assign cfg_busy = (state_q != ST_IDLE);
    assign cfg_done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_eth_mac_cfg_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_eth_mac_cfg_ctrl
// Description : Directed self-checking bench for eth_mac_cfg_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_eth_mac_cfg_ctrl;

    logic        clk156 = 1'b0;
    logic        sys_rst;
    logic        cfg_wr_en;
    logic [1:0]  cfg_addr;
    logic [31:0] cfg_wr_data;
    logic [31:0] cfg_rd_data;
    logic        link_up, tx_idle, rx_idle;
    logic [79:0] tx_vec, rx_vec;
    logic        cfg_busy, cfg_done;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [47:0] MAC0 = 48'h001122334455;
    localparam logic [47:0] MAC2 = 48'h02AABBCCDDEE;

    always #5 clk156 = ~clk156;

    eth_mac_cfg_ctrl dut (
        .clk156                      (clk156),
        .sys_rst                     (sys_rst),
        .cfg_wr_en                   (cfg_wr_en),
        .cfg_addr                    (cfg_addr),
        .cfg_wr_data                 (cfg_wr_data),
        .cfg_rd_data                 (cfg_rd_data),
        .link_up                     (link_up),
        .tx_idle                     (tx_idle),
        .rx_idle                     (rx_idle),
        .mac_tx_configuration_vector (tx_vec),
        .mac_rx_configuration_vector (rx_vec),
        .cfg_busy                    (cfg_busy),
        .cfg_done                    (cfg_done)
    );

    task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [79:0] exp_vec(input logic [47:0] mac, input logic jumbo,
                                            input logic vlan, input logic en, input logic rx);
        logic [79:0] v;
        v          = '0;
        v[79:32]   = mac;
        v[30:16]   = 15'd1518;
        v[4]       = jumbo;
        v[2]       = vlan;
        v[1]       = en;
        if (rx) v[9:8] = 2'b11;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk156);
        #1;
    endtask

    task automatic cfg_write(input logic [1:0] a, input logic [31:0] d);
        cfg_wr_en   = 1'b1;
        cfg_addr    = a;
        cfg_wr_data = d;
        tick();
        cfg_wr_en   = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        cfg_addr = a;
        #1;
        d = cfg_rd_data;
    endtask

    // Cycles (after the current edge) until cfg_done; -1 if the budget expires.
    task automatic run_to_done(input int budget, input logic [47:0] mac,
                               output int t_done, output int t_mac);
        t_done = -1;
        t_mac  = 0;
        for (int i = 1; i <= budget; i++) begin
            tick();
            if (t_mac == 0 && tx_vec[79:32] == mac) t_mac = i;
            if (cfg_done) begin
                t_done = i;
                break;
            end
        end
    endtask

    initial begin
        logic [31:0] d;
        int          t_done, t_mac, pulses;

        sys_rst = 1'b1; cfg_wr_en = 1'b0; cfg_addr = 2'd0; cfg_wr_data = '0;
        link_up = 1'b0; tx_idle = 1'b1; rx_idle = 1'b1;
        tick(); tick();
        sys_rst = 1'b0;

        // Reset state
        check("rst_busy", 80'(cfg_busy), 80'd1);
        check("rst_done", 80'(cfg_done), 80'd0);
        check("rst_txvec", tx_vec, exp_vec(MAC0, 1, 1, 0, 0));
        check("rst_rxvec", rx_vec, exp_vec(MAC0, 1, 1, 0, 1));
        rd(2'd3, d); check("rst_status", 80'(d), 80'h09);
        rd(2'd2, d); check("rst_ctrl", 80'(d), 80'h0F);
        tick();
        rd(2'd0, d); check("rst_maclo", 80'(d), 80'h22334455);
        rd(2'd1, d); check("rst_machi", 80'(d), 80'h0011);
        tick(); tick();

        // 1: link up enables both directions one cycle later
        link_up = 1'b1;
        tick();
        check("t1_done", 80'(cfg_done), 80'd1);
        check("t1_busy", 80'(cfg_busy), 80'd0);
        check("t1_txvec", tx_vec, exp_vec(MAC0, 1, 1, 1, 0));
        check("t1_rxvec", rx_vec, exp_vec(MAC0, 1, 1, 1, 1));
        tick();
        check("t1_done_pulse", 80'(cfg_done), 80'd0);

        // 2: new MAC and commit with idle datapath
        cfg_write(2'd0, 32'hBBCCDDEE);
        cfg_write(2'd1, 32'h000002AA);
        check("t2_mac_unchanged", tx_vec, exp_vec(MAC0, 1, 1, 1, 0));
        cfg_write(2'd2, 32'h1F);
        check("t2_en_drop", tx_vec, exp_vec(MAC0, 1, 1, 0, 0));
        check("t2_busy", 80'(cfg_busy), 80'd1);
        run_to_done(100, MAC2, t_done, t_mac);
        check("t2_latency", 80'(t_done), 80'd19);
        check("t2_mac_apply", 80'(t_mac), 80'd18);
        check("t2_txvec", tx_vec, exp_vec(MAC2, 1, 1, 1, 0));
        check("t2_rxvec", rx_vec, exp_vec(MAC2, 1, 1, 1, 1));

        // 3: drain timeout
        tx_idle = 1'b0;
        cfg_write(2'd2, 32'h1F);
        run_to_done(5000, MAC2, t_done, t_mac);
        check("t3_latency", 80'(t_done), 80'd4114);
        tx_idle = 1'b1;
        rd(2'd3, d); check("t3_status", 80'(d), 80'h10);

        // 4: second commit during QUIET
        tick();
        cfg_write(2'd2, 32'h1F);
        for (int i = 0; i < 5; i++) tick();
        cfg_write(2'd2, 32'h1F);
        rd(2'd3, d); check("t4_status_err", 80'(d), 80'h35);
        run_to_done(100, MAC2, t_done, t_mac);
        check("t4_latency", 80'(t_done), 80'd13);
        pulses = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (cfg_done) pulses++;
        end
        check("t4_no_restart", 80'(pulses), 80'd0);
        cfg_write(2'd2, 32'h4F);
        rd(2'd3, d); check("t4_clear", 80'(d), 80'h00);

        // 5: commit with link down holds in ENABLE
        link_up = 1'b0;
        tick();
        cfg_write(2'd2, 32'h1F);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (cfg_done) pulses++;
        end
        check("t5_no_done", 80'(pulses), 80'd0);
        check("t5_txvec", tx_vec, exp_vec(MAC2, 1, 1, 0, 0));
        rd(2'd3, d); check("t5_status", 80'(d), 80'h09);
        link_up = 1'b1;
        tick();
        check("t5_done", 80'(cfg_done), 80'd1);
        check("t5_rxvec", rx_vec, exp_vec(MAC2, 1, 1, 1, 1));
        link_up = 1'b0;
        tick(); tick(); tick();
        check("t5_link_drop", tx_vec, exp_vec(MAC2, 1, 1, 1, 0));
        link_up = 1'b1;

        // 6: partial enables, jumbo off, then reset mid-DRAIN
        cfg_write(2'd2, 32'h19);
        run_to_done(100, MAC2, t_done, t_mac);
        check("t6_latency", 80'(t_done), 80'd19);
        check("t6_txvec", tx_vec, exp_vec(MAC2, 0, 1, 1, 0));
        check("t6_rxvec", rx_vec, exp_vec(MAC2, 0, 1, 0, 1));
        tx_idle = 1'b0;
        cfg_write(2'd2, 32'h1F);
        tick(); tick(); tick();
        rd(2'd3, d); check("t6_in_drain", 80'(d), 80'h03);
        sys_rst = 1'b1;
        tick();
        sys_rst = 1'b0;
        tx_idle = 1'b1;
        check("t6_rst_busy", 80'(cfg_busy), 80'd1);
        check("t6_rst_txvec", tx_vec, exp_vec(MAC0, 1, 1, 0, 0));
        rd(2'd3, d); check("t6_rst_status", 80'(d), 80'h09);
        rd(2'd0, d); check("t6_rst_maclo", 80'(d), 80'h22334455);
        tick();
        check("t6_reenable_done", 80'(cfg_done), 80'd1);
        check("t6_reenable_rx", rx_vec, exp_vec(MAC0, 1, 1, 1, 1));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
